// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern modes,
// colour-bar table and default 640x480 timing.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_BARS     = 3'd0,
    MODE_GRADIENT = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_SOLID    = 3'd3,
    MODE_BOX      = 3'd4
  } mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int BAR_COUNT = 8;

  // Bar colours as {R,G,B} on/off flags, left to right.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters with sync and active-region decode; outputs are the
// unregistered decode of the current counter state.
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          origin
);

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic line_end;
  logic frame_end;

  assign line_end  = (hcnt == HW'(HT - 1));
  assign frame_end = (vcnt == VW'(VT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Compare in 32 bits so an end bound equal to the total never truncates.
  assign active = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
  assign hsync  = (32'(hcnt) >= HS_START) && (32'(hcnt) < HS_END);
  assign vsync  = (32'(vcnt) >= VS_START) && (32'(vcnt) < VS_END);
  assign origin = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern generator: raster timing plus a two-stage colour pipeline
// whose mode and solid colour are frozen at the start of each frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2:0]      MODE,
  input  logic [3*CW-1:0] SOLID_RGB,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_DE,
  output logic            FRAME_START
);

  localparam int HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(HT);
  localparam int VW        = $clog2(VT);
  localparam int BOX       = 1 << CHK_LOG2;
  localparam int BOX_Y     = V_ACTIVE / 2;
  localparam int GRAD_FRAC = 16;
  localparam int GRAD_DEN  = (H_ACTIVE > 1) ? H_ACTIVE - 1 : 1;
  localparam logic [63:0] CW_MAX     = (64'd1 << CW) - 64'd1;
  // Rounded up so the last active pixel reaches full scale.
  localparam logic [63:0] GRAD_SCALE =
    ((CW_MAX << GRAD_FRAC) + 64'(GRAD_DEN) - 64'd1) / 64'(GRAD_DEN);

  function automatic logic [CW-1:0] grad_level(input logic [HW-1:0] x);
    logic [63:0] scaled;
    scaled = (64'(x) * GRAD_SCALE) >> GRAD_FRAC;
    if (scaled > CW_MAX) return '1;
    return scaled[CW-1:0];
  endfunction

  function automatic logic [3*CW-1:0] expand_rgb(input logic [2:0] f);
    return {{CW{f[2]}}, {CW{f[1]}}, {CW{f[0]}}};
  endfunction

  // Box X advances by 2 per frame modulo H_ACTIVE, snapping to 0 when the
  // 8-bit frame counter wraps.
  function automatic logic [HW-1:0] next_box_pos(input logic [HW-1:0] pos,
                                                 input logic [7:0]    fc);
    logic [HW:0] sum;
    if (fc == 8'hFF) return '0;
    sum = {1'b0, pos} + (HW+1)'(2);
    if (sum >= (HW+1)'(H_ACTIVE)) sum = sum - (HW+1)'(H_ACTIVE);
    return sum[HW-1:0];
  endfunction

  // Asynchronous assert, two-flop synchronised release.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active;
  logic          hsync;
  logic          vsync;
  logic          origin;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk    (CLK),
    .rst_n  (rst_n),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .active (active),
    .hsync  (hsync),
    .vsync  (vsync),
    .origin (origin)
  );

  // Stage p0 -> p1: bar index from precomputed ceil(i*H_ACTIVE/8) bounds.
  logic [2:0] bar_p0;

  always_comb begin
    bar_p0 = 3'd0;
    for (int i = 1; i < BAR_COUNT; i++) begin
      if (32'(hcnt) >= (i * H_ACTIVE + BAR_COUNT - 1) / BAR_COUNT) bar_p0 = 3'(i);
    end
  end

  logic            vld_p1;
  logic            hs_p1;
  logic            vs_p1;
  logic            fs_p1;
  logic [HW-1:0]   hcnt_p1;
  logic [VW-1:0]   vcnt_p1;
  logic [2:0]      bar_p1;
  mode_e           mode_lat;
  logic [3*CW-1:0] solid_lat;
  logic [HW-1:0]   box_x;
  logic [HW-1:0]   box_pos;
  logic [7:0]      frame_cnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      fs_p1     <= 1'b0;
      hcnt_p1   <= '0;
      vcnt_p1   <= '0;
      bar_p1    <= '0;
      mode_lat  <= MODE_BARS;
      solid_lat <= '0;
      box_x     <= '0;
      box_pos   <= '0;
      frame_cnt <= '0;
    end else begin
      vld_p1  <= active;
      hs_p1   <= hsync;
      vs_p1   <= vsync;
      fs_p1   <= origin;
      hcnt_p1 <= hcnt;
      vcnt_p1 <= vcnt;
      bar_p1  <= bar_p0;
      if (origin) begin
        mode_lat  <= mode_e'(MODE);
        solid_lat <= SOLID_RGB;
        box_x     <= box_pos;
        box_pos   <= next_box_pos(box_pos, frame_cnt);
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Stage p1 -> p2: colour selection, blanked outside the active region.
  logic [3*CW-1:0] colour_p2;
  logic [CW-1:0]   grad_p2;
  logic            in_box_p2;

  always_comb begin
    grad_p2   = grad_level(hcnt_p1);
    in_box_p2 = (hcnt_p1 >= box_x) && (32'(hcnt_p1) < 32'(box_x) + BOX) &&
                (32'(vcnt_p1) >= BOX_Y) && (32'(vcnt_p1) < BOX_Y + BOX);
    colour_p2 = '0;
    case (mode_lat)
      MODE_BARS:     colour_p2 = expand_rgb(bar_rgb(bar_p1));
      MODE_GRADIENT: colour_p2 = {grad_p2, grad_p2, grad_p2};
      MODE_CHECKER:  colour_p2 = (hcnt_p1[CHK_LOG2] ^ vcnt_p1[CHK_LOG2]) ? '1 : '0;
      MODE_SOLID:    colour_p2 = solid_lat;
      MODE_BOX:      colour_p2 = in_box_p2 ? '1 : '0;
      default:       colour_p2 = '0;
    endcase
    if (!vld_p1) colour_p2 = '0;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_DE      <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      FRAME_START <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= colour_p2;
      VGA_DE      <= vld_p1;
      VGA_HS      <= hs_p1 ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_p1 ? VS_POL : ~VS_POL;
      FRAME_START <= fs_p1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench: a default 640x480 instance for colour bars and a tiny-raster
// instance (H 16/2/2/2, V 8/1/1/1, 2-pixel squares) for everything else.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode_b;
  logic [23:0] solid_b;
  logic [2:0]  mode_t;
  logic [23:0] solid_t;

  logic [7:0] r_b, g_b, b_b;
  logic       hs_b, vs_b, de_b, fs_b;
  logic [7:0] r_t, g_t, b_t;
  logic       hs_t, vs_t, de_t, fs_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_pattern_gen dut_big (
    .CLK         (clk),
    .RST         (rst),
    .MODE        (mode_b),
    .SOLID_RGB   (solid_b),
    .VGA_R       (r_b),
    .VGA_G       (g_b),
    .VGA_B       (b_b),
    .VGA_HS      (hs_b),
    .VGA_VS      (vs_b),
    .VGA_DE      (de_b),
    .FRAME_START (fs_b)
  );

  video_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CHK_LOG2 (1)
  ) dut_tiny (
    .CLK         (clk),
    .RST         (rst),
    .MODE        (mode_t),
    .SOLID_RGB   (solid_t),
    .VGA_R       (r_t),
    .VGA_G       (g_t),
    .VGA_B       (b_t),
    .VGA_HS      (hs_t),
    .VGA_VS      (vs_t),
    .VGA_DE      (de_t),
    .FRAME_START (fs_t)
  );

  // Expected {HS,VS,DE,FS} of the tiny raster at cycle k of a frame (HT=22, VT=11).
  function automatic logic [3:0] tiny_timing(input int k);
    int h;
    int v;
    h = k % 22;
    v = k / 22;
    return {!(h >= 18 && h < 20), !(v == 9), (h < 16 && v < 8), (k == 0)};
  endfunction

  // Expected tiny-raster colour for a mode at pixel (h,v).
  function automatic logic [23:0] tiny_rgb(input int m, input int h, input int v,
                                           input logic [23:0] solid, input int bx);
    logic [7:0] g;
    if (h >= 16 || v >= 8) return 24'h000000;
    case (m)
      0: case (h * 8 / 16)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      1: begin
        g = 8'(h * 255 / 15);
        return {g, g, g};
      end
      2: return ((((h / 2) ^ (v / 2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3: return solid;
      4: return (h >= bx && h < bx + 2 && v >= 4 && v < 6) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(negedge clk);
    checks++; if ({r_t, g_t, b_t} !== 24'h0) begin errors++; $display("FAIL reset_rgb_tiny: got %h, required 000000", {r_t, g_t, b_t}); end
    checks++; if ({hs_t, vs_t, de_t, fs_t} !== 4'b1100) begin errors++; $display("FAIL reset_ctrl_tiny: got %b, required 1100", {hs_t, vs_t, de_t, fs_t}); end
    checks++; if ({r_b, g_b, b_b} !== 24'h0) begin errors++; $display("FAIL reset_rgb_big: got %h, required 000000", {r_b, g_b, b_b}); end
    checks++; if ({hs_b, vs_b, de_b, fs_b} !== 4'b1100) begin errors++; $display("FAIL reset_ctrl_big: got %b, required 1100", {hs_b, vs_b, de_b, fs_b}); end
    rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 20);
    checks++; if (n != 4 || fs_t !== 1'b1) begin errors++; $display("FAIL release_latency: fs after %0d cycles (fs=%b), required 4", n, fs_t); end
    checks++; if (fs_b !== 1'b1 || de_t !== 1'b1) begin errors++; $display("FAIL release_align: fs_b=%b de_t=%b, required 1 1", fs_b, de_t); end
    repeat (3) @(negedge clk);
    checks++; if ({r_b, g_b, b_b} !== 24'hFFFFFF) begin errors++; $display("FAIL run_pixel3_big: got %h, required FFFFFF", {r_b, g_b, b_b}); end
    checks++; if ({r_t, g_t, b_t} !== 24'hFFFFFF) begin errors++; $display("FAIL run_pixel3_tiny: got %h, required FFFFFF", {r_t, g_t, b_t}); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({r_b, g_b, b_b, de_b, hs_b, vs_b} !== 27'b011) begin errors++; $display("FAIL async_reset_big: rgb=%h de=%b hs=%b vs=%b, required 000000 0 1 1", {r_b, g_b, b_b}, de_b, hs_b, vs_b); end
    checks++; if ({r_t, g_t, b_t, de_t, hs_t, vs_t, fs_t} !== 28'b0110) begin errors++; $display("FAIL async_reset_tiny: rgb=%h de=%b hs=%b vs=%b fs=%b", {r_t, g_t, b_t}, de_t, hs_t, vs_t, fs_t); end
    @(negedge clk);
  endtask

  task automatic test_checker_timing;
    int n;
    int de_cnt;
    int hs_low;
    mode_t = 3'd2;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 40);
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL checker_fs_wait: fs=%b after %0d cycles, required 1", fs_t, n); end
    de_cnt = 0;
    hs_low = 0;
    for (int k = 0; k < 242; k++) begin
      checks++; if ({hs_t, vs_t, de_t, fs_t} !== tiny_timing(k)) begin errors++; $display("FAIL checker_timing k=%0d: got %b, required %b", k, {hs_t, vs_t, de_t, fs_t}, tiny_timing(k)); end
      checks++; if ({r_t, g_t, b_t} !== tiny_rgb(2, k % 22, k / 22, 24'h0, 0)) begin errors++; $display("FAIL checker_pixel k=%0d: got %h, required %h", k, {r_t, g_t, b_t}, tiny_rgb(2, k % 22, k / 22, 24'h0, 0)); end
      if (de_t === 1'b1) de_cnt++;
      if (hs_t === 1'b0) hs_low++;
      @(negedge clk);
    end
    checks++; if (de_cnt != 128) begin errors++; $display("FAIL checker_de_count: got %0d, required 128", de_cnt); end
    checks++; if (hs_low != 22) begin errors++; $display("FAIL checker_hs_low_count: got %0d, required 22", hs_low); end
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL checker_frame_period: fs=%b at cycle 242, required 1", fs_t); end
  endtask

  task automatic test_bars;
    int n;
    logic [23:0] exp_c;
    mode_t = 3'd0;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_b !== 1'b1 && n < 40);
    checks++; if (fs_b !== 1'b1) begin errors++; $display("FAIL bars_fs_wait: fs=%b after %0d cycles, required 1", fs_b, n); end
    for (int k = 0; k <= 640; k++) begin
      if (k < 22) begin
        checks++; if ({r_t, g_t, b_t} !== tiny_rgb(0, k, 0, 24'h0, 0)) begin errors++; $display("FAIL bars_tiny k=%0d: got %h, required %h", k, {r_t, g_t, b_t}, tiny_rgb(0, k, 0, 24'h0, 0)); end
      end
      if (k == 0 || k == 79 || k == 80 || k == 160 || k == 639) begin
        case (k)
          80:      exp_c = 24'hFFFF00;
          160:     exp_c = 24'h00FFFF;
          639:     exp_c = 24'h000000;
          default: exp_c = 24'hFFFFFF;
        endcase
        checks++; if ({de_b, r_b, g_b, b_b} !== {1'b1, exp_c}) begin errors++; $display("FAIL bars_big px=%0d: de=%b rgb=%h, required 1 %h", k, de_b, {r_b, g_b, b_b}, exp_c); end
      end
      if (k == 640) begin
        checks++; if ({de_b, r_b, g_b, b_b} !== 25'h0) begin errors++; $display("FAIL bars_big_blank: de=%b rgb=%h, required 0 000000", de_b, {r_b, g_b, b_b}); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gradient;
    int n;
    mode_t = 3'd1;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 40);
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL grad_fs_wait: fs=%b after %0d cycles, required 1", fs_t, n); end
    for (int k = 0; k < 44; k++) begin
      checks++; if ({r_t, g_t, b_t} !== tiny_rgb(1, k % 22, k / 22, 24'h0, 0)) begin errors++; $display("FAIL grad_pixel k=%0d: got %h, required %h", k, {r_t, g_t, b_t}, tiny_rgb(1, k % 22, k / 22, 24'h0, 0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_solid_midframe;
    int n;
    logic [23:0] exp_solid;
    mode_t = 3'd3;
    solid_t = 24'h123456;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 40);
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL solid_fs_wait: fs=%b after %0d cycles, required 1", fs_t, n); end
    for (int k = 0; k < 484; k++) begin
      exp_solid = (k < 242) ? 24'h123456 : 24'hABCDEF;
      checks++; if ({hs_t, vs_t, de_t, fs_t} !== tiny_timing(k % 242)) begin errors++; $display("FAIL solid_timing k=%0d: got %b, required %b", k, {hs_t, vs_t, de_t, fs_t}, tiny_timing(k % 242)); end
      checks++; if ({r_t, g_t, b_t} !== tiny_rgb(3, k % 22, (k % 242) / 22, exp_solid, 0)) begin errors++; $display("FAIL solid_pixel k=%0d: got %h, required %h", k, {r_t, g_t, b_t}, tiny_rgb(3, k % 22, (k % 242) / 22, exp_solid, 0)); end
      if (k == 100) solid_t = 24'hABCDEF;
      @(negedge clk);
    end
  endtask

  task automatic test_mode6_black;
    int n;
    int de_cnt;
    mode_t = 3'd6;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 40);
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL mode6_fs_wait: fs=%b after %0d cycles, required 1", fs_t, n); end
    de_cnt = 0;
    for (int k = 0; k < 242; k++) begin
      checks++; if ({hs_t, vs_t, de_t, fs_t} !== tiny_timing(k)) begin errors++; $display("FAIL mode6_timing k=%0d: got %b, required %b", k, {hs_t, vs_t, de_t, fs_t}, tiny_timing(k)); end
      checks++; if ({r_t, g_t, b_t} !== 24'h000000) begin errors++; $display("FAIL mode6_pixel k=%0d: got %h, required 000000", k, {r_t, g_t, b_t}); end
      if (de_t === 1'b1) de_cnt++;
      @(negedge clk);
    end
    checks++; if (de_cnt != 128) begin errors++; $display("FAIL mode6_de_count: got %0d, required 128", de_cnt); end
  endtask

  task automatic test_box_wrap;
    int n;
    int bx;
    int perr;
    int fs_cnt;
    mode_t = 3'd4;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end while (fs_t !== 1'b1 && n < 40);
    checks++; if (fs_t !== 1'b1) begin errors++; $display("FAIL box_fs_wait: fs=%b after %0d cycles, required 1", fs_t, n); end
    fs_cnt = 0;
    for (int f = 0; f <= 256; f++) begin
      bx = ((f % 256) * 2) % 16;
      perr = 0;
      for (int k = 0; k < 242; k++) begin
        if ({hs_t, vs_t, de_t, fs_t} !== tiny_timing(k)) perr++;
        if ({r_t, g_t, b_t} !== tiny_rgb(4, k % 22, k / 22, 24'h0, bx)) perr++;
        if (f < 256 && fs_t === 1'b1) fs_cnt++;
        if (f == 255 && k == 88 + 14) begin
          checks++; if ({r_t, g_t, b_t} !== 24'hFFFFFF) begin errors++; $display("FAIL box_frame255_x14: got %h, required FFFFFF", {r_t, g_t, b_t}); end
        end
        if (f == 256 && k == 88) begin
          checks++; if ({r_t, g_t, b_t} !== 24'hFFFFFF) begin errors++; $display("FAIL box_wrap_x0: got %h, required FFFFFF", {r_t, g_t, b_t}); end
        end
        @(negedge clk);
      end
      checks++; if (perr != 0) begin errors++; $display("FAIL box_frame f=%0d: %0d mismatching samples, required 0", f, perr); end
    end
    checks++; if (fs_cnt != 256) begin errors++; $display("FAIL box_fs_count: got %0d, required 256", fs_cnt); end
  endtask

  initial begin
    rst     = 1'b1;
    mode_b  = 3'd0;
    solid_b = 24'h0;
    mode_t  = 3'd2;
    solid_t = 24'h0;
    #1 rst = 1'b0;
    test_reset();
    test_checker_timing();
    test_bars();
    test_gradient();
    test_solid_midframe();
    test_mode6_black();
    test_box_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
